csr_access_controller: RTL and testbench
========================================

Name: csr_access_controller

Overview:
Initiator side of the CSR access interface. It sits in the execute stage, accepts one Zicsr instruction at a time (CSRRW/S/C and the immediate forms), and reads the CSR unit's combinational read port. It computes the read-modify-write value, issues a single write pulse and waits for write_done. It then returns the old CSR value for rd writeback, and stalls the pipeline while busy.

Parameters:
DATA_WIDTH, 32, CSR and register data width
ADDR_WIDTH, 12, CSR address width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  execute stage presents a valid CSR instruction
flush  in  1  pipeline flush; cancels or suppresses the in-flight access
func3_in  in  3  instruction func3
rs1_index  in  5  rs1 field; also the uimm for the immediate forms
rd_index  in  5  destination register index
csr_addr_in  in  12  CSR address from the instruction
rs1_value  in  32  forwarded rs1 operand
busy  out  1  stall request to the pipeline
done  out  1  one-cycle completion pulse
rd_write_enable  out  1  qualifies rd_value, valid with done
rd_out  out  5  latched rd index, valid with done
rd_value  out  32  old CSR value, valid with done
illegal_instruction  out  1  valid with done; no CSR state changed
csr_write_enable  out  1  write strobe to the CSR unit
csr_write_done  in  1  write acknowledge from the CSR unit
csr_func3  out  3  latched func3
csr_imm  out  5  latched uimm
csr_addr  out  12  latched CSR address
csr_write_data  out  32  computed new CSR value
csr_read_data  in  32  combinational read data from the CSR unit

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state IDLE; every output is 0, including busy, done, csr_write_enable and illegal_instruction.
- FSM states: IDLE, READ, WRITE, WAIT_ACK, DONE.
- IDLE:
  - When start=1 and flush=0, latch func3, rs1_index, rd_index, csr_addr_in and rs1_value.
  - Set busy=1 from the next cycle.
  - Go to READ, or to DONE with illegal set if the instruction is illegal.
  - A start pulse coinciding with flush is ignored.
- Illegal conditions:
  - func3 is 000 or 100.
  - A write is required and csr_addr[11:10]==2'b11 (read-only CSR).
  - On illegal: no csr_write_enable, rd_write_enable=0.
- Write required:
  - CSRRW/CSRRWI always write.
  - CSRRS/CSRRC/CSRRSI/CSRRCI write only if rs1_index != 0.
- READ (one cycle):
  - csr_addr is stable from the latched copy.
  - Sample csr_read_data into old_value.
  - Compute the operand: rs1_value for the register forms (001/010/011); the zero-extended uimm for the immediate forms (101/110/111).
  - new value for W forms = operand.
  - new value for S forms = old | operand.
  - new value for C forms = old & ~operand.
  - Register new_value to csr_write_data.
  - Next state is WRITE if a write is required, otherwise DONE.
- WRITE: csr_write_enable=1 for exactly one cycle, then go to WAIT_ACK.
- WAIT_ACK: hold until csr_write_done=1, then go to DONE. There is no timeout; the CSR unit guarantees the acknowledge one cycle after the strobe.
- DONE (one cycle):
  - done=1, busy=0.
  - rd_write_enable=1 when not illegal and rd_index != 0.
  - rd_value=old_value.
  - Return to IDLE.
  - A new start is accepted from IDLE only, so there is a minimum of one idle cycle between accesses.
- Latency from start accepted at cycle T:
  - No-write access: done at T+2.
  - Write access: strobe at T+2, acknowledge at T+3, done at T+4.
- busy=1 in READ, WRITE and WAIT_ACK.
- Flush rules:
  - Flush in READ aborts to IDLE with no done and no write.
  - Flush in WRITE or WAIT_ACK does not abort, because the write is already committed. The FSM still completes to DONE, but rd_write_enable is forced to 0.
  - Flush in DONE forces rd_write_enable to 0.
- Reset mid-operation returns to IDLE immediately and drops all strobes; a partially issued write is abandoned.
- Arithmetic is 32-bit bitwise only; the uimm is zero-extended to 32 bits.

Decomposition:
- Shared package csr_pkg:
  - func3 encodings: CSRRW=3'b001, CSRRS=3'b010, CSRRC=3'b011, CSRRWI=3'b101, CSRRSI=3'b110, CSRRCI=3'b111.
  - The FSM state enum.
  - CSR address constants, shared with the CSR unit.
- One natural combinational sub-module, csr_rmw_alu: inputs func3, old, rs1_value and uimm; outputs new_value, write_required and uses_imm.

Test Plan:
- Read, no write: CSRRS with rs1=x0, addr 0x340 (MSCRATCH = 0xDEADBEEF), rd=x5 -> done at T+2, rd_value=0xDEADBEEF, rd_write_enable=1, csr_write_enable never asserted.
- Set bits: CSRRS with rs1_value=0x0000000F on addr 0x304 (MIE = 0x00000880) -> csr_write_data=0x0000088F, one strobe at T+2, done at T+4, rd_value=0x00000880.
- Clear with immediate: CSRRCI with uimm=5'h08 on addr 0x300 (MSTATUS = 0x00001888) -> csr_write_data=0x00001880.
- Illegal: CSRRW to 0xC00 -> done at T+1 with illegal_instruction=1, no strobe, rd_write_enable=0. func3=3'b100 -> same response.
- Flush: flush during READ -> no done and no strobe, back in IDLE. Flush during WAIT_ACK -> write completes, done=1, rd_write_enable=0.
- Reset asserted in WRITE -> next cycle all outputs are 0 and the FSM is in IDLE; a subsequent CSRRW with rd=x0 gives done=1 and rd_write_enable=0.

Source files
------------

// File: rtl/csr_access_controller_pkg.sv
// Shared CSR definitions: func3 encodings, controller FSM states, CSR addresses.
// No logic of its own; helpers are pure combinational functions.
// Imported by the access controller, its RMW ALU and the CSR unit.
package csr_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;

  // addr[11:10] == 2'b11 marks a read-only CSR
  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_WAIT_ACK,
    ST_DONE
  } csr_state_e;

  // func3 000 and 100 are not Zicsr encodings
  function automatic logic csr_func3_legal(input logic [2:0] func3);
    return (func3[1:0] != 2'b00);
  endfunction

  // Swap forms always write; set/clear forms only with a non-zero rs1/uimm field
  function automatic logic csr_write_required(input logic [2:0] func3,
                                              input logic [4:0] rs1_field);
    if (func3[1:0] == 2'b01) return 1'b1;
    return (rs1_field != 5'd0);
  endfunction

endpackage

// File: rtl/csr_access_controller_if.sv
// Bundle of pipeline-side and CSR-unit-side signals of the CSR access controller.
// No latency; pure wiring.
// master = controller, slave = pipeline plus CSR unit.
interface csr_access_controller_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  start;
  logic                  flush;
  logic [2:0]            func3_in;
  logic [4:0]            rs1_index;
  logic [4:0]            rd_index;
  logic [ADDR_WIDTH-1:0] csr_addr_in;
  logic [DATA_WIDTH-1:0] rs1_value;
  logic                  busy;
  logic                  done;
  logic                  rd_write_enable;
  logic [4:0]            rd_out;
  logic [DATA_WIDTH-1:0] rd_value;
  logic                  illegal_instruction;
  logic                  csr_write_enable;
  logic                  csr_write_done;
  logic [2:0]            csr_func3;
  logic [4:0]            csr_imm;
  logic [ADDR_WIDTH-1:0] csr_addr;
  logic [DATA_WIDTH-1:0] csr_write_data;
  logic [DATA_WIDTH-1:0] csr_read_data;

  modport master (
    input  start, flush, func3_in, rs1_index, rd_index, csr_addr_in, rs1_value,
    input  csr_write_done, csr_read_data,
    output busy, done, rd_write_enable, rd_out, rd_value, illegal_instruction,
    output csr_write_enable, csr_func3, csr_imm, csr_addr, csr_write_data
  );

  modport slave (
    output start, flush, func3_in, rs1_index, rd_index, csr_addr_in, rs1_value,
    output csr_write_done, csr_read_data,
    input  busy, done, rd_write_enable, rd_out, rd_value, illegal_instruction,
    input  csr_write_enable, csr_func3, csr_imm, csr_addr, csr_write_data
  );
endinterface

// File: rtl/csr_access_controller_rmw_alu.sv
// Read-modify-write value for Zicsr swap/set/clear, register or immediate operand.
// Purely combinational, zero latency.
// No handshake; result is consumed in the controller's READ state.
module csr_rmw_alu
  import csr_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            func3_i,
  input  logic [DATA_WIDTH-1:0] old_i,
  input  logic [DATA_WIDTH-1:0] rs1_value_i,
  input  logic [4:0]            uimm_i,
  output logic [DATA_WIDTH-1:0] new_value_o,
  output logic                  write_required_o,
  output logic                  uses_imm_o
);
  logic [DATA_WIDTH-1:0] operand;

  assign uses_imm_o       = func3_i[2];
  assign write_required_o = csr_write_required(func3_i, uimm_i);
  assign operand          = uses_imm_o ? {{(DATA_WIDTH-5){1'b0}}, uimm_i} : rs1_value_i;

  // func3[1:0] selects swap / set / clear independent of operand source
  always_comb begin
    new_value_o = old_i;
    case (func3_i[1:0])
      2'b01:   new_value_o = operand;
      2'b10:   new_value_o = old_i | operand;
      2'b11:   new_value_o = old_i & ~operand;
      default: new_value_o = old_i;
    endcase
  end
endmodule

// File: rtl/csr_access_controller.sv
// Execute-stage initiator for CSR read-modify-write accesses, one at a time.
// Done 2 cycles after accept without write, 4 with write, 1 when illegal.
// Stalls pipeline via busy; waits indefinitely on csr_write_done.
module csr_access_controller
  import csr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  csr_access_controller_if.master    bus
);
  csr_state_e            state_q, state_d;
  logic [2:0]            func3_q, func3_d;
  logic [4:0]            rs1_q, rs1_d;
  logic [4:0]            rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rs1_val_q, rs1_val_d;
  logic [DATA_WIDTH-1:0] old_q, old_d;
  logic [DATA_WIDTH-1:0] new_q, new_d;
  logic                  illegal_q, illegal_d;
  logic                  kill_q, kill_d;

  logic [DATA_WIDTH-1:0] alu_new;
  logic                  alu_wr_req;
  logic                  alu_uses_imm;
  logic                  illegal_in;

  csr_rmw_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .func3_i          (func3_q),
    .old_i            (bus.csr_read_data),
    .rs1_value_i      (rs1_val_q),
    .uimm_i           (rs1_q),
    .new_value_o      (alu_new),
    .write_required_o (alu_wr_req),
    .uses_imm_o       (alu_uses_imm)
  );

  // Legality is decided from the raw instruction so illegal ops skip straight to DONE
  assign illegal_in = !csr_func3_legal(bus.func3_in) ||
                      (csr_write_required(bus.func3_in, bus.rs1_index) &&
                       (bus.csr_addr_in[ADDR_WIDTH-1 -: 2] == CSR_RO_PREFIX));

  // State and latched-operand registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      func3_q   <= '0;
      rs1_q     <= '0;
      rd_q      <= '0;
      addr_q    <= '0;
      rs1_val_q <= '0;
      old_q     <= '0;
      new_q     <= '0;
      illegal_q <= 1'b0;
      kill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      func3_q   <= func3_d;
      rs1_q     <= rs1_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      rs1_val_q <= rs1_val_d;
      old_q     <= old_d;
      new_q     <= new_d;
      illegal_q <= illegal_d;
      kill_q    <= kill_d;
    end
  end

  // Next-state logic; kill records a flush that arrived after the write was committed
  always_comb begin
    state_d   = state_q;
    func3_d   = func3_q;
    rs1_d     = rs1_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    rs1_val_d = rs1_val_q;
    old_d     = old_q;
    new_d     = new_q;
    illegal_d = illegal_q;
    kill_d    = kill_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          func3_d   = bus.func3_in;
          rs1_d     = bus.rs1_index;
          rd_d      = bus.rd_index;
          addr_d    = bus.csr_addr_in;
          rs1_val_d = bus.rs1_value;
          old_d     = '0;
          illegal_d = illegal_in;
          kill_d    = 1'b0;
          state_d   = illegal_in ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          old_d   = bus.csr_read_data;
          new_d   = alu_new;
          state_d = alu_wr_req ? ST_WRITE : ST_DONE;
        end
      end
      ST_WRITE: begin
        if (bus.flush) kill_d = 1'b1;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (bus.flush) kill_d = 1'b1;
        if (bus.csr_write_done) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy                = (state_q == ST_READ) || (state_q == ST_WRITE) ||
                                   (state_q == ST_WAIT_ACK);
  assign bus.done                = (state_q == ST_DONE);
  assign bus.illegal_instruction = (state_q == ST_DONE) && illegal_q;
  assign bus.rd_write_enable     = (state_q == ST_DONE) && !illegal_q && !kill_q &&
                                   !bus.flush && (rd_q != 5'd0);
  assign bus.rd_out              = rd_q;
  assign bus.rd_value            = old_q;
  assign bus.csr_write_enable    = (state_q == ST_WRITE);
  assign bus.csr_func3           = func3_q;
  assign bus.csr_imm             = rs1_q;
  assign bus.csr_addr            = addr_q;
  assign bus.csr_write_data      = new_q;

  logic unused_ok;
  assign unused_ok = alu_uses_imm;
endmodule

// File: tb/tb_csr_access_controller.sv
// Directed bench for csr_access_controller with a small CSR unit model.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
// CSR model acknowledges every write strobe one cycle later.
module tb_csr_access_controller;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  csr_access_controller_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus ();

  csr_access_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // CSR unit model: combinational read, write on strobe, ack one cycle later
  logic [31:0] mstatus_r, mie_r, mscratch_r;
  initial begin
    mstatus_r  = 32'h0000_1888;
    mie_r      = 32'h0000_0880;
    mscratch_r = 32'hDEAD_BEEF;
  end

  always_comb begin
    case (bus.csr_addr)
      12'h300: bus.csr_read_data = mstatus_r;
      12'h304: bus.csr_read_data = mie_r;
      12'h340: bus.csr_read_data = mscratch_r;
      12'hC00: bus.csr_read_data = 32'h0000_1234;
      default: bus.csr_read_data = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    bus.csr_write_done <= reset ? 1'b0 : bus.csr_write_enable;
    if (!reset && bus.csr_write_enable) begin
      case (bus.csr_addr)
        12'h300: mstatus_r  <= bus.csr_write_data;
        12'h304: mie_r      <= bus.csr_write_data;
        12'h340: mscratch_r <= bus.csr_write_data;
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one instruction for one cycle; returns in cycle T+1
  task automatic issue(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rd,
                       input logic [11:0] addr, input logic [31:0] val);
    bus.func3_in    = f3;
    bus.rs1_index   = rs1;
    bus.rd_index    = rd;
    bus.csr_addr_in = addr;
    bus.rs1_value   = val;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.flush       = 1'b0;
    bus.func3_in    = 3'b000;
    bus.rs1_index   = 5'd0;
    bus.rd_index    = 5'd0;
    bus.csr_addr_in = 12'h000;
    bus.rs1_value   = 32'h0;
    tick();
    tick();

    // Reset state
    chk("rst_busy",   {31'b0, bus.busy}, 32'd0);
    chk("rst_done",   {31'b0, bus.done}, 32'd0);
    chk("rst_strobe", {31'b0, bus.csr_write_enable}, 32'd0);
    chk("rst_ill",    {31'b0, bus.illegal_instruction}, 32'd0);
    chk("rst_wdata",  bus.csr_write_data, 32'd0);
    reset = 1'b0;
    tick();

    // Read only: CSRRS x5, mscratch, x0
    issue(3'b010, 5'd0, 5'd5, 12'h340, 32'hFFFF_FFFF);
    chk("rd_t1_busy",   {31'b0, bus.busy}, 32'd1);
    chk("rd_t1_strobe", {31'b0, bus.csr_write_enable}, 32'd0);
    chk("rd_t1_done",   {31'b0, bus.done}, 32'd0);
    tick();
    chk("rd_t2_done",   {31'b0, bus.done}, 32'd1);
    chk("rd_t2_busy",   {31'b0, bus.busy}, 32'd0);
    chk("rd_t2_strobe", {31'b0, bus.csr_write_enable}, 32'd0);
    chk("rd_t2_value",  bus.rd_value, 32'hDEAD_BEEF);
    chk("rd_t2_we",     {31'b0, bus.rd_write_enable}, 32'd1);
    chk("rd_t2_rd",     {27'b0, bus.rd_out}, 32'd5);
    tick();
    chk("rd_t3_done",   {31'b0, bus.done}, 32'd0);

    // Set bits: CSRRS x6, mie, x1=0xF
    issue(3'b010, 5'd1, 5'd6, 12'h304, 32'h0000_000F);
    chk("set_t1_strobe", {31'b0, bus.csr_write_enable}, 32'd0);
    tick();
    chk("set_t2_strobe", {31'b0, bus.csr_write_enable}, 32'd1);
    chk("set_t2_wdata",  bus.csr_write_data, 32'h0000_088F);
    chk("set_t2_addr",   {20'b0, bus.csr_addr}, 32'h304);
    chk("set_t2_done",   {31'b0, bus.done}, 32'd0);
    tick();
    chk("set_t3_strobe", {31'b0, bus.csr_write_enable}, 32'd0);
    chk("set_t3_busy",   {31'b0, bus.busy}, 32'd1);
    chk("set_t3_done",   {31'b0, bus.done}, 32'd0);
    tick();
    chk("set_t4_done",   {31'b0, bus.done}, 32'd1);
    chk("set_t4_value",  bus.rd_value, 32'h0000_0880);
    chk("set_t4_we",     {31'b0, bus.rd_write_enable}, 32'd1);
    tick();

    // Clear with immediate: CSRRCI x7, mstatus, 8; flush in DONE kills rd write
    issue(3'b111, 5'h08, 5'd7, 12'h300, 32'hFFFF_FFFF);
    tick();
    chk("clri_t2_strobe", {31'b0, bus.csr_write_enable}, 32'd1);
    chk("clri_t2_wdata",  bus.csr_write_data, 32'h0000_1880);
    chk("clri_t2_imm",    {27'b0, bus.csr_imm}, 32'h08);
    tick();
    tick();
    chk("clri_t4_done",   {31'b0, bus.done}, 32'd1);
    chk("clri_t4_value",  bus.rd_value, 32'h0000_1888);
    chk("clri_t4_we",     {31'b0, bus.rd_write_enable}, 32'd1);
    bus.flush = 1'b1;
    #1;
    chk("clri_t4_flush_we", {31'b0, bus.rd_write_enable}, 32'd0);
    tick();
    bus.flush = 1'b0;

    // Illegal: CSRRW to read-only 0xC00
    issue(3'b001, 5'd1, 5'd3, 12'hC00, 32'h1);
    chk("ill_ro_done",   {31'b0, bus.done}, 32'd1);
    chk("ill_ro_ill",    {31'b0, bus.illegal_instruction}, 32'd1);
    chk("ill_ro_we",     {31'b0, bus.rd_write_enable}, 32'd0);
    chk("ill_ro_strobe", {31'b0, bus.csr_write_enable}, 32'd0);
    tick();
    chk("ill_ro_after",  {31'b0, bus.done | bus.busy}, 32'd0);

    // Illegal: func3 = 100
    issue(3'b100, 5'd0, 5'd3, 12'h300, 32'h1);
    chk("ill_f3_done",   {31'b0, bus.done}, 32'd1);
    chk("ill_f3_ill",    {31'b0, bus.illegal_instruction}, 32'd1);
    chk("ill_f3_we",     {31'b0, bus.rd_write_enable}, 32'd0);
    tick();

    // Start coinciding with flush is ignored
    bus.flush = 1'b1;
    issue(3'b001, 5'd1, 5'd4, 12'h340, 32'h1);
    bus.flush = 1'b0;
    chk("stfl_busy", {31'b0, bus.busy}, 32'd0);
    chk("stfl_done", {31'b0, bus.done}, 32'd0);

    // Flush during READ aborts
    issue(3'b001, 5'd1, 5'd4, 12'h340, 32'h1234_5678);
    chk("flrd_t1_busy", {31'b0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flrd_t2_busy",   {31'b0, bus.busy}, 32'd0);
    chk("flrd_t2_done",   {31'b0, bus.done}, 32'd0);
    chk("flrd_t2_strobe", {31'b0, bus.csr_write_enable}, 32'd0);
    tick();
    chk("flrd_t3_done",   {31'b0, bus.done}, 32'd0);
    chk("flrd_t3_strobe", {31'b0, bus.csr_write_enable}, 32'd0);

    // Flush during WAIT_ACK: write completes, rd write suppressed
    issue(3'b001, 5'd2, 5'd9, 12'h340, 32'hCAFE_F00D);
    tick();
    chk("flwa_t2_strobe", {31'b0, bus.csr_write_enable}, 32'd1);
    tick();
    chk("flwa_t3_busy",   {31'b0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flwa_t4_done",   {31'b0, bus.done}, 32'd1);
    chk("flwa_t4_we",     {31'b0, bus.rd_write_enable}, 32'd0);
    chk("flwa_t4_value",  bus.rd_value, 32'hDEAD_BEEF);
    tick();

    // Reset asserted while in WRITE
    issue(3'b001, 5'd1, 5'd10, 12'h304, 32'h0000_0055);
    tick();
    chk("rstw_t2_strobe", {31'b0, bus.csr_write_enable}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstw_busy",   {31'b0, bus.busy}, 32'd0);
    chk("rstw_done",   {31'b0, bus.done}, 32'd0);
    chk("rstw_strobe", {31'b0, bus.csr_write_enable}, 32'd0);
    chk("rstw_wdata",  bus.csr_write_data, 32'd0);
    chk("rstw_addr",   {20'b0, bus.csr_addr}, 32'd0);
    chk("rstw_rdval",  bus.rd_value, 32'd0);
    tick();
    chk("rstw_idle",   {31'b0, bus.busy | bus.done}, 32'd0);

    // CSRRW with rd = x0: done without rd write
    issue(3'b001, 5'd1, 5'd0, 12'h340, 32'h0000_0001);
    tick();
    chk("rdx0_t2_strobe", {31'b0, bus.csr_write_enable}, 32'd1);
    tick();
    tick();
    chk("rdx0_t4_done",   {31'b0, bus.done}, 32'd1);
    chk("rdx0_t4_we",     {31'b0, bus.rd_write_enable}, 32'd0);
    chk("rdx0_t4_value",  bus.rd_value, 32'hCAFE_F00D);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
